pushbutton_array: RTL and testbench

- Parametrised successor to the single-channel pushbutton debouncer, used on dev-board switches and slow probe/control inputs feeding the correlator tops.
- Handles N_BTN independent channels, each with an input synchroniser, counter-based debounce, toggle state, one-cycle press and release pulses, and long-press detection.
- Sits between raw board pins and user logic in the 48MHz domain.

---
 rtl/pushbutton_array.sv | 94 +++++++++
 tb/tb_pushbutton_array.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_array.sv
// N_BTN independent debounced pushbutton channels: synchroniser, counter debounce,
// toggle, press/release pulses and saturating long-press detection.
module pushbutton_array #(
  parameter int N_BTN         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_EXP  = 16,
  parameter int LONGPRESS_EXP = 24,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic [N_BTN-1:0] i_button,
  output logic [N_BTN-1:0] o_debounced,
  output logic [N_BTN-1:0] o_toggle,
  output logic [N_BTN-1:0] o_pressPulse,
  output logic [N_BTN-1:0] o_releasePulse,
  output logic [N_BTN-1:0] o_longPress,
  output logic [N_BTN-1:0] o_longPulse
);

  logic [N_BTN-1:0] pre;
  assign pre = i_button ^ {N_BTN{ACTIVE_LOW}};

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0]   sync_reg;
    logic [DEBOUNCE_EXP-1:0]  deb_cnt_reg;
    logic [LONGPRESS_EXP-1:0] long_cnt_reg;
    logic deb_reg, tog_reg, press_reg, release_reg, long_reg, long_pulse_reg;
    logic sync, deb_fire, rel_fire;

    assign sync     = sync_reg[SYNC_STAGES-1];
    assign deb_fire = (sync != deb_reg) && (deb_cnt_reg == '1);
    // A release on the very edge the long counter saturates must not raise o_longPress.
    assign rel_fire = deb_fire && deb_reg;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_reg       <= '0;
        deb_cnt_reg    <= '0;
        long_cnt_reg   <= '0;
        deb_reg        <= 1'b0;
        tog_reg        <= 1'b0;
        press_reg      <= 1'b0;
        release_reg    <= 1'b0;
        long_reg       <= 1'b0;
        long_pulse_reg <= 1'b0;
      end else begin
        press_reg      <= 1'b0;
        release_reg    <= 1'b0;
        long_pulse_reg <= 1'b0;
        if (i_cg) begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], pre[gi]};

          if (sync == deb_reg) begin
            deb_cnt_reg <= '0;
          end else if (!deb_fire) begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end else begin
            deb_cnt_reg <= '0;
            deb_reg     <= sync;
            if (sync) begin
              press_reg <= 1'b1;
              tog_reg   <= ~tog_reg;
            end else begin
              release_reg <= 1'b1;
              long_reg    <= 1'b0;
            end
          end

          // Counter saturates at all-ones once the long press is flagged.
          if (!deb_reg) begin
            long_cnt_reg <= '0;
          end else if (!long_reg && !rel_fire) begin
            if (long_cnt_reg == '1) begin
              long_reg       <= 1'b1;
              long_pulse_reg <= 1'b1;
            end else begin
              long_cnt_reg <= long_cnt_reg + 1'b1;
            end
          end
        end
      end
    end

    assign o_debounced[gi]    = deb_reg;
    assign o_toggle[gi]       = tog_reg;
    assign o_pressPulse[gi]   = press_reg;
    assign o_releasePulse[gi] = release_reg;
    assign o_longPress[gi]    = long_reg;
    assign o_longPulse[gi]    = long_pulse_reg;
  end

endmodule

// File: tb/tb_pushbutton_array.sv
// Scoreboard bench for pushbutton_array: stimulus queues expected output events,
// a negedge monitor pops and compares whenever any output pulses or changes level.
module tb_pushbutton_array;

  typedef struct {
    int         cyc;
    logic [3:0] pp, rp, lpu, deb, tog, lp;
  } ev_t;

  logic clk = 1'b0;
  logic rst, cg;
  logic [3:0] btn_a, btn_b;
  logic [3:0] a_deb, a_tog, a_pp, a_rp, a_lp, a_lpu;
  logic [3:0] b_deb, b_tog, b_pp, b_rp, b_lp, b_lpu;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   armed = 1'b0;
  ev_t  qa[$];
  ev_t  qb[$];
  logic [11:0] prev_a, prev_b;
  logic [3:0]  tog_seq [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pushbutton_array #(.N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_EXP(3), .LONGPRESS_EXP(5),
                     .ACTIVE_LOW(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_button(btn_a),
    .o_debounced(a_deb), .o_toggle(a_tog), .o_pressPulse(a_pp),
    .o_releasePulse(a_rp), .o_longPress(a_lp), .o_longPulse(a_lpu));

  pushbutton_array #(.N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_EXP(3), .LONGPRESS_EXP(5),
                     .ACTIVE_LOW(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cg(1'b1), .i_button(btn_b),
    .o_debounced(b_deb), .o_toggle(b_tog), .o_pressPulse(b_pp),
    .o_releasePulse(b_rp), .o_longPress(b_lp), .o_longPulse(b_lpu));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input bit sel_b, input int c, input logic [3:0] pp, rp, lpu,
                           deb, tog, lp);
    ev_t e;
    e = '{c, pp, rp, lpu, deb, tog, lp};
    if (sel_b) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  function automatic void cmp_ev(input string nm, input ev_t g, input ev_t e);
    vectors++;
    if (g.cyc != e.cyc || g.pp != e.pp || g.rp != e.rp || g.lpu != e.lpu ||
        g.deb != e.deb || g.tog != e.tog || g.lp != e.lp) begin
      miscompares++;
      $display("FAIL %s: got cyc=%0d pp=%b rp=%b lpu=%b deb=%b tog=%b lp=%b, want cyc=%0d pp=%b rp=%b lpu=%b deb=%b tog=%b lp=%b",
               nm, g.cyc, g.pp, g.rp, g.lpu, g.deb, g.tog, g.lp,
               e.cyc, e.pp, e.rp, e.lpu, e.deb, e.tog, e.lp);
    end else begin
      $display("%s cyc=%0d pp=%b rp=%b lpu=%b deb=%b tog=%b lp=%b ok",
               nm, g.cyc, g.pp, g.rp, g.lpu, g.deb, g.tog, g.lp);
    end
  endfunction

  // Monitor: any pulse or level change on either instance is an observed event.
  always @(negedge clk) begin
    ev_t g;
    if (armed) begin
      g = '{cyc, a_pp, a_rp, a_lpu, a_deb, a_tog, a_lp};
      if ((a_pp | a_rp | a_lpu) != 4'b0 || {a_deb, a_tog, a_lp} != prev_a) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ev_a unexpected: cyc=%0d pp=%b rp=%b lpu=%b deb=%b tog=%b lp=%b, want no event",
                   cyc, a_pp, a_rp, a_lpu, a_deb, a_tog, a_lp);
        end else begin
          cmp_ev("ev_a", g, qa.pop_front());
        end
      end
      prev_a = {a_deb, a_tog, a_lp};

      g = '{cyc, b_pp, b_rp, b_lpu, b_deb, b_tog, b_lp};
      if ((b_pp | b_rp | b_lpu) != 4'b0 || {b_deb, b_tog, b_lp} != prev_b) begin
        if (qb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ev_b unexpected: cyc=%0d pp=%b rp=%b lpu=%b deb=%b tog=%b lp=%b, want no event",
                   cyc, b_pp, b_rp, b_lpu, b_deb, b_tog, b_lp);
        end else begin
          cmp_ev("ev_b", g, qb.pop_front());
        end
      end
      prev_b = {b_deb, b_tog, b_lp};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; cg = 1'b1; btn_a = 4'b0000; btn_b = 4'b1111;
    tog_seq[0] = 4'b1111; tog_seq[1] = 4'b0111; tog_seq[2] = 4'b1111;
    step(3);
    rst = 1'b0;

    // Reset state of both instances.
    vectors++;
    if ({a_deb, a_tog, a_pp, a_rp, a_lp, a_lpu} != 24'h0) begin
      miscompares++;
      $display("FAIL reset_a: got %h, want 000000", {a_deb, a_tog, a_pp, a_rp, a_lp, a_lpu});
    end else $display("reset_a ok");
    vectors++;
    if ({b_deb, b_tog, b_pp, b_rp, b_lp, b_lpu} != 24'h0) begin
      miscompares++;
      $display("FAIL reset_b: got %h, want 000000", {b_deb, b_tog, b_pp, b_rp, b_lp, b_lpu});
    end else $display("reset_b ok");
    prev_a = {a_deb, a_tog, a_lp};
    prev_b = {b_deb, b_tog, b_lp};
    armed = 1'b1;
    step(10);

    // Clean press and release on ch0.
    c = cyc; btn_a = 4'b0001;
    expect_ev(0, c + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    expect_ev(0, c + 22, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step(12); btn_a = 4'b0000; step(15);

    // 7-cycle glitch on ch1 is rejected; then a press with a 1-cycle bounce.
    btn_a = 4'b0010; step(7); btn_a = 4'b0000; step(12);
    c = cyc; btn_a = 4'b0010;
    expect_ev(0, c + 16, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 4'b0000);
    expect_ev(0, c + 28, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0000);
    step(5); btn_a = 4'b0000; step(1); btn_a = 4'b0010;
    step(12); btn_a = 4'b0000; step(15);

    // Long press on ch2 held for 60 cycles.
    c = cyc; btn_a = 4'b0100;
    expect_ev(0, c + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0111, 4'b0000);
    expect_ev(0, c + 42, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0111, 4'b0100);
    expect_ev(0, c + 70, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0111, 4'b0000);
    step(60); btn_a = 4'b0000; step(15);

    // Three presses on ch3, then simultaneous ch0 + ch3.
    for (int i = 0; i < 3; i++) begin
      c = cyc; btn_a = 4'b1000;
      expect_ev(0, c + 10, 4'b1000, 4'b0000, 4'b0000, 4'b1000, tog_seq[i], 4'b0000);
      expect_ev(0, c + 22, 4'b0000, 4'b1000, 4'b0000, 4'b0000, tog_seq[i], 4'b0000);
      step(12); btn_a = 4'b0000; step(12);
    end
    c = cyc; btn_a = 4'b1001;
    expect_ev(0, c + 10, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b0110, 4'b0000);
    expect_ev(0, c + 22, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0110, 4'b0000);
    step(12); btn_a = 4'b0000; step(15);

    // Clock gate held low 20 cycles mid-debounce, then low again as the pulse appears.
    c = cyc; btn_a = 4'b0001;
    expect_ev(0, c + 30, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0111, 4'b0000);
    expect_ev(0, c + 43, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0111, 4'b0000);
    step(5); cg = 1'b0; step(20); cg = 1'b1; step(5);
    cg = 1'b0; step(3); cg = 1'b1; btn_a = 4'b0000; step(15);

    // Reset during a long press on ch2; the held button re-presses from scratch.
    c = cyc; btn_a = 4'b0100;
    expect_ev(0, c + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0011, 4'b0000);
    expect_ev(0, c + 21, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(0, c + 31, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    expect_ev(0, c + 43, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    step(20); rst = 1'b1; step(1); rst = 1'b0;
    step(12); btn_a = 4'b0000; step(15);

    // Active-low instance: ch1 driven low is a press.
    c = cyc; btn_b = 4'b1101;
    expect_ev(1, c + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    expect_ev(1, c + 22, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    step(12); btn_b = 4'b1111; step(20);

    // Every expected event must have been observed.
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL drain_a: %0d events still pending, want 0", qa.size());
    end else $display("drain_a ok");
    vectors++;
    if (qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_b: %0d events still pending, want 0", qb.size());
    end else $display("drain_b ok");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
